// File: rtl/vip_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vip_uart_pkg
// Brief    : Shared receive-FSM states and oversampling constants for the
//            UART sniffer.
// Revision : 1.0 - initial release
// ============================================================================
package vip_uart_pkg;

    localparam int         c_OVS_FACTOR = 16;
    localparam logic [3:0] c_MID_SAMPLE = 4'd7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_e;

    function automatic int calc_ovs_div(input int clk_freq, input int baud_rate);
        return clk_freq / (c_OVS_FACTOR * baud_rate);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vip_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : vip_uart_rx_fifo
// Brief    : First-word-fall-through byte FIFO. A push into a full FIFO is
//            accepted only when a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module vip_uart_rx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic       full,
    output logic       empty,
    output logic [7:0] rdata
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $fatal(1, "vip_uart_rx_fifo: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [7:0]         r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_wr;
    logic               w_rd;

    assign full  = (r_count == c_CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign w_rd  = pop && !empty;
    assign w_wr  = push && (!full || w_rd);
    assign rdata = empty ? 8'h00 : r_mem[r_rptr];

    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/vip_uart_rx_sniffer.sv
`default_nettype none
// ============================================================================
// Module   : vip_uart_rx_sniffer
// Brief    : 8N1 UART receiver with 16x oversampling, byte FIFO, valid/ready
//            drain port and framing-error / overflow pulses.
// Revision : 1.0 - initial release
// ============================================================================
module vip_uart_rx_sniffer
    import vip_uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overflow_o,
    output logic       busy_o
);

    localparam int c_OVS_DIV = calc_ovs_div(CLK_FREQ, BAUD_RATE);
    localparam int c_TICK_W  = (c_OVS_DIV > 1) ? $clog2(c_OVS_DIV) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_MAX = c_TICK_W'(c_OVS_DIV - 1);

    generate
        if (c_OVS_DIV < 1) begin : g_bad_ovs_div
            $fatal(1, "vip_uart_rx_sniffer: CLK_FREQ/(16*BAUD_RATE) must be >= 1");
        end
    endgenerate

    logic                r_sync1;
    logic                r_sync2;
    logic                w_rx_s;
    logic [c_TICK_W-1:0] r_tick_cnt;
    logic                w_tick;
    logic [3:0]          r_scnt;
    logic                w_mid;
    logic [2:0]          r_bitcnt;
    logic [7:0]          r_shreg;
    rx_state_e           r_state;
    rx_state_e           w_state_nxt;
    logic                w_start;
    logic                w_shift;
    logic                w_push_req;
    logic                w_ferr_req;
    logic                r_push;
    logic                r_frame_err;
    logic                r_overflow;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_i;
            r_sync2 <= r_sync1;
        end
    end
    assign w_rx_s = r_sync2;

    assign w_tick = (r_tick_cnt == c_TICK_MAX);
    assign w_mid  = w_tick && (r_scnt == c_MID_SAMPLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tick_cnt <= '0;
            r_scnt     <= '0;
            r_bitcnt   <= '0;
            r_shreg    <= '0;
        end else begin
            if (w_start || w_tick) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
            end

            if (w_start) begin
                r_scnt <= '0;
            end else if (w_tick && r_state != IDLE) begin
                r_scnt <= r_scnt + 4'd1;
            end

            if (w_start) begin
                r_bitcnt <= '0;
            end else if (w_shift) begin
                r_bitcnt <= r_bitcnt + 3'd1;
            end

            // LSB arrives first, so shifting right leaves bit 0 in place after 8 samples.
            if (w_shift) begin
                r_shreg <= {w_rx_s, r_shreg[7:1]};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_shift     = 1'b0;
        w_push_req  = 1'b0;
        w_ferr_req  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = START;
                    w_start     = 1'b1;
                end
            end
            START: begin
                if (w_mid) begin
                    w_state_nxt = w_rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_mid) begin
                    w_shift = 1'b1;
                    if (r_bitcnt == 3'd7) begin
                        w_state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (w_mid) begin
                    if (w_rx_s) begin
                        w_push_req  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_ferr_req  = 1'b1;
                        w_state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                // A held-low line must return high before a new start is accepted.
                if (w_rx_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_push      <= w_push_req;
            r_frame_err <= w_ferr_req;
            r_overflow  <= r_push && w_full && !w_pop;
        end
    end

    assign w_pop = valid_o && ready_i;

    vip_uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (r_push),
        .pop   (w_pop),
        .wdata (r_shreg),
        .full  (w_full),
        .empty (w_empty),
        .rdata (data_o)
    );

    assign valid_o     = !w_empty;
    assign frame_err_o = r_frame_err;
    assign overflow_o  = r_overflow;
    assign busy_o      = (r_state != IDLE);

endmodule
`default_nettype wire
